// File: rtl/arb_pkg.sv
// Shared constants for the unified memory arbiter: FSM state codes, grant
// codes and default widths used by the top level and the grant selector.
package arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/arb_grant_select.sv
// Grant decision between fetch and data requesters. Data normally wins, but a
// fetch that has waited through STARVE_LIMIT data grants is served first.
module arb_grant_select
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_fire,
  output logic grant
);

  localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

  starve_cnt_t starve_cnt;

  function automatic starve_cnt_t sat_inc(input starve_cnt_t v);
    return (v >= LIMIT) ? LIMIT : v + starve_cnt_t'(1);
  endfunction

  always_comb begin
    grant = GNT_IF;
    if (d_req && !(if_req && (starve_cnt == LIMIT)))
      grant = GNT_D;
  end

  // Only data grants made while a fetch is waiting count toward starvation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_fire) begin
      if (grant == GNT_IF)
        starve_cnt <= '0;
      else if (if_req)
        starve_cnt <= sat_inc(starve_cnt);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one transaction at a time. Define ARB_PERF_CNT_EN to build the stall counter.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall,
  output logic [31:0]       perf_stall_cnt
);

  logic [1:0] state;
  logic       grant_sel;
  logic       grant_q;
  logic       grant_fire;

  assign grant_fire = (state == IDLE) && (if_req || d_req);
  assign pipe_stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  arb_grant_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_select (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .d_req     (d_req),
    .grant_fire(grant_fire),
    .grant     (grant_sel)
  );

  // Responses are only honoured in WAIT, so stray or stale strobes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= GNT_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            grant_q <= grant_sel;
            mem_req <= 1'b1;
            if (grant_sel == GNT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (grant_q == GNT_IF) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (pipe_stall)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter with a transaction-level model of
// requesters and memory, plus directed fetch/store/contention/starvation cases.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_RESP  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          pipe_stall;
  logic [31:0]   perf_stall_cnt;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pipe_stall(pipe_stall), .perf_stall_cnt(perf_stall_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state
  int            phase = PH_IDLE;
  bit            gnt = 1'b0;
  logic [AW-1:0] t_addr = '0;
  bit            t_we = 1'b0;
  logic [DW-1:0] t_wdata = '0;
  int            starve = 0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  logic [DW-1:0] resp_data = '0;
  logic [DW-1:0] memory [logic [AW-1:0]];
  bit            cur_ifv = 1'b0;
  bit            cur_dv = 1'b0;
  logic [31:0]   perf_model = '0;
  bit            gnt_log[$];
  int            if_seen = 0;
  int            d_seen = 0;

  // stimulus knobs
  int if_left = 0, d_left = 0, gap_pct = 100;
  int rdy_lo = 0, rdy_pct = 100, wait_fix = 0, wait_cnt = 0;
  int stray_pct = 0, stray_force = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (memory.exists(a)) return memory[a];
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  task automatic step();
    bit            rst_s, ifq_s, dq_s, rdy_s, rv_s;
    rst_s = reset;
    ifq_s = if_req;
    dq_s  = d_req;
    rdy_s = mem_ready;
    rv_s  = mem_rvalid && (phase == PH_WAIT);
    if (rst_s) perf_model = '0;
    else perf_model = perf_model + 32'((ifq_s & ~cur_ifv) | (dq_s & ~cur_dv));
    @(negedge clk);
    cyc++;
    if (if_valid) if_seen++;
    if (d_valid) d_seen++;
    if (rst_s) begin
      phase = PH_IDLE; starve = 0; m_if_rdata = '0; m_d_rdata = '0;
      cur_ifv = 1'b0; cur_dv = 1'b0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_pipe_stall", pipe_stall, if_req | d_req);
      chk("rst_perf", perf_stall_cnt, 0);
    end else begin
      case (phase)
        PH_IDLE: begin
          if (ifq_s || dq_s) begin
            if (ifq_s && dq_s) gnt = (starve == SL) ? 1'b0 : 1'b1;
            else gnt = dq_s;
            if (gnt) begin
              t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
              if (ifq_s && starve < SL) starve++;
            end else begin
              t_addr = if_addr; t_we = 1'b0; t_wdata = '0;
              starve = 0;
            end
            gnt_log.push_back(gnt);
            chk("issue_mem_req", mem_req, 1);
            chk("issue_mem_we", mem_we, t_we);
            chk("issue_mem_addr", mem_addr, t_addr);
            if (t_we) chk("issue_mem_wdata", mem_wdata, t_wdata);
            phase = PH_ISSUE;
          end else begin
            chk("idle_mem_req", mem_req, 0);
          end
        end
        PH_ISSUE: begin
          if (rdy_s) begin
            chk("accept_mem_req_drop", mem_req, 0);
            if (t_we) memory[t_addr] = t_wdata;
            wait_cnt = (wait_fix >= 0) ? wait_fix : $urandom_range(0, 4);
            phase = PH_WAIT;
          end else begin
            chk("hold_mem_req", mem_req, 1);
            chk("hold_mem_we", mem_we, t_we);
            chk("hold_mem_addr", mem_addr, t_addr);
            if (t_we) chk("hold_mem_wdata", mem_wdata, t_wdata);
          end
        end
        PH_WAIT: begin
          if (rv_s) phase = PH_RESP;
          chk("wait_mem_req", mem_req, 0);
        end
        default: begin
          phase = PH_IDLE;
          chk("resp_mem_req", mem_req, 0);
        end
      endcase
      cur_ifv = (phase == PH_RESP) && !gnt;
      cur_dv  = (phase == PH_RESP) && gnt;
      if (cur_ifv) m_if_rdata = resp_data;
      if (cur_dv && !t_we) m_d_rdata = resp_data;
      chk("if_valid", if_valid, cur_ifv);
      chk("d_valid", d_valid, cur_dv);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("pipe_stall", pipe_stall, (if_req & ~cur_ifv) | (d_req & ~cur_dv));
`ifdef ARB_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, perf_model);
`else
      chk("perf_stall_cnt_off", perf_stall_cnt, 0);
`endif
    end
    // requesters: the completing one drops or replaces its request now
    if (phase == PH_RESP) begin
      if (!gnt) if_req = 1'b0;
      else d_req = 1'b0;
    end
    if (!if_req && if_left > 0 && $urandom_range(0, 99) < gap_pct) begin
      if_req = 1'b1; if_addr = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4; if_left--;
    end
    if (!d_req && d_left > 0 && $urandom_range(0, 99) < gap_pct) begin
      d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
      d_addr = 32'h1001_0000 + 32'($urandom_range(0, 15)) * 4;
      d_wdata = $urandom; d_left--;
    end
    // memory side
    mem_ready  = $urandom_range(0, 1) == 1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (phase == PH_ISSUE) begin
      if (rdy_lo > 0) begin mem_ready = 1'b0; rdy_lo--; end
      else mem_ready = $urandom_range(0, 99) < rdy_pct;
    end
    if (phase == PH_WAIT) begin
      if (wait_cnt == 0) begin
        resp_data = t_we ? DW'($urandom) : mem_read(t_addr);
        mem_rvalid = 1'b1; mem_rdata = resp_data;
      end else begin
        wait_cnt--;
      end
    end else if (stray_force > 0 || $urandom_range(0, 99) < stray_pct) begin
      mem_rvalid = 1'b1;
      if (stray_force > 0) stray_force--;
    end
  endtask

  task automatic run_quiet(input string name, input int max_cyc);
    int n = 0;
    while (!(phase == PH_IDLE && !if_req && !d_req && if_left == 0 && d_left == 0) && n < max_cyc) begin
      step(); n++;
    end
    checks++;
    if (n >= max_cyc) begin
      failures++;
      $display("FAIL %s timeout actual=%0d cycles required<%0d", name, n, max_cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step();
    reset = 1'b0; step();
  endtask

  initial begin
    int lat;
    int seen0;
    logic [4:0] order;
    do_reset();

    // lone fetch, literal values
    memory[32'h0040_0000] = 32'h2008_0005;
    rdy_pct = 100; wait_fix = 1; stray_pct = 0;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    lat = 0;
    do begin step(); lat++; end while (!cur_ifv && lat < 20);
    chk("fetch_latency", lat, 4);
    chk("fetch_rdata_lit", if_rdata, 32'h2008_0005);
    chk("fetch_mem_addr_lit", mem_addr, 32'h0040_0000);
    chk("fetch_mem_we_lit", mem_we, 0);
    step();

    // store, then load back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("store_mem_we_lit", mem_we, 1);
    chk("store_mem_wdata_lit", mem_wdata, 32'hDEAD_BEEF);
    run_quiet("store", 50);
    chk("store_d_rdata_unchanged_lit", d_rdata, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
    run_quiet("load", 50);
    chk("load_back_lit", d_rdata, 32'hDEAD_BEEF);
    step();

    // contention: data first, then fetch
    gnt_log.delete();
    if_req = 1'b1; if_addr = 32'h0040_0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
    run_quiet("contention", 60);
    chk("contention_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("contention_first_d", gnt_log[0], 1);
      chk("contention_second_if", gnt_log[1], 0);
    end

    // starvation with fetch held and back-to-back data
    do_reset();
    gnt_log.delete();
    gap_pct = 100; if_left = 2; d_left = 5;
    run_quiet("starvation", 200);
    chk("starve_grants", gnt_log.size(), 7);
    if (gnt_log.size() >= 5) begin
      order = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3], gnt_log[4]};
      chk("starve_order_DDIFDD", order, 5'b11011);
    end

    // wait states with strays in ISSUE
    step();
    seen0 = d_seen;
    rdy_lo = 3; wait_fix = 4; stray_pct = 60;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
    run_quiet("wait_states", 60);
    chk("wait_single_valid", d_seen - seen0, 1);
    chk("wait_rdata_lit", d_rdata, 32'hDEAD_BEEF);

    // randomized traffic
    rdy_pct = 60; wait_fix = -1; stray_pct = 15; gap_pct = 30;
    if_left = 60; d_left = 60;
    run_quiet("random", 6000);

    // reset in WAIT, stale response afterwards
    if_left = 4; d_left = 4; gap_pct = 100; rdy_pct = 100; wait_fix = 3; stray_pct = 0;
    lat = 0;
    while (phase != PH_WAIT && lat < 100) begin step(); lat++; end
    chk("reached_wait", phase, PH_WAIT);
    seen0 = if_seen + d_seen;
    reset = 1'b1; step(); step();
    reset = 1'b0; stray_force = 2;
    step(); step();
    chk("no_valid_after_reset", if_seen + d_seen - seen0, 0);
    wait_fix = -1;
    run_quiet("after_reset", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
